// File: rtl/alu_arbiter_if.sv
// Signal bundle between alu_arbiter, its two clients and alu_top.
// The arbiter uses the slave modport; client/ALU-side logic uses master.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        rsp0_valid;
    logic [15:0] rsp0_result;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic [15:0] rsp1_result;
    logic        rsp1_err;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_done, alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_err,
        output alu_start, alu_op, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_done, alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_err,
        input  alu_start, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin front end for two clients sharing alu_top; one operation in flight.
//   state | meaning
//   IDLE  | no operation; grant computed combinationally from valids and ptr
//   ISSUE | alu_start pulse, timeout counter loaded
//   WAIT  | waiting for alu_done or timeout
//   RESP  | one-cycle response to the latched requester, ptr flips
module alu_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic         busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] OP_RSVD  = 3'd7;
    localparam logic [7:0] CNT_LOAD = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic        grant;
    logic        accept;
    logic        rsp_sel;

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign grant  = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
    assign accept = (state_q == S_IDLE) & ~reset & (bus.req0_valid | bus.req1_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d = grant;
                    if (grant) begin
                        op_d = bus.req1_op;
                        a_d  = bus.req1_a;
                        b_d  = bus.req1_b;
                    end else begin
                        op_d = bus.req0_op;
                        a_d  = bus.req0_a;
                        b_d  = bus.req0_b;
                    end
                    if (op_d == OP_RSVD) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested before terminal count so a late completion still wins.
                if (bus.alu_done) begin
                    res_d   = bus.alu_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == 8'd0) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                ptr_d   = ~id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;

    always_comb begin
        rsp_sel          = (state_q == S_RESP);
        busy_o           = (state_q != S_IDLE);
        bus.alu_start    = (state_q == S_ISSUE);
        bus.req0_ready   = accept & ~grant;
        bus.req1_ready   = accept & grant;
        bus.rsp0_valid   = rsp_sel & ~id_q;
        bus.rsp1_valid   = rsp_sel & id_q;
        bus.rsp0_result  = (rsp_sel & ~id_q) ? res_q : 16'h0000;
        bus.rsp1_result  = (rsp_sel & id_q) ? res_q : 16'h0000;
        bus.rsp0_err     = rsp_sel & ~id_q & err_q;
        bus.rsp1_err     = rsp_sel & id_q & err_q;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;
    localparam int TO = 8;

    typedef struct {
        int          cyc;
        logic [15:0] res;
        logic        err;
    } rsp_t;

    typedef struct {
        int         cyc;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } st_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mptr        = 1'b0;
    int   alu_delay   = 3;
    bit   alu_never   = 1'b0;
    rsp_t q0[$];
    rsp_t q1[$];
    st_t  qs[$];

    alu_arbiter_if bus();

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0: return 16'(sa + sb);
            3'd1: return 16'(sa - sb);
            3'd2: return 16'(sa * sb);
            3'd3: return (sb == 0) ? 16'hFFFF : 16'(sa / sb);
            3'd4: return {8'h00, a & b};
            3'd5: return {8'h00, a | b};
            3'd6: return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [58:0] outs();
        return {busy, bus.req0_ready, bus.req1_ready,
                bus.rsp0_valid, bus.rsp0_err, bus.rsp0_result,
                bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result,
                bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b};
    endfunction

    // ALU stand-in: done 'alu_delay' cycles after start, result from the reference ALU.
    initial begin
        int          cnt;
        bit          pend;
        logic [15:0] sres;
        cnt  = 0;
        pend = 1'b0;
        sres = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            #3;
            bus.alu_done   = 1'b0;
            bus.alu_result = 16'($urandom);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        bus.alu_done   = 1'b1;
                        bus.alu_result = sres;
                        pend           = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.alu_start === 1'b1) begin
                    pend = !alu_never;
                    cnt  = alu_delay - 1;
                    sres = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
                end
            end
        end
    end

    initial begin
        rsp_t r;
        st_t  s;
        forever begin
            @(negedge clk);
            #2;
            if (bus.rsp0_valid === 1'b1) begin
                r.cyc = cyc; r.res = bus.rsp0_result; r.err = bus.rsp0_err;
                q0.push_back(r);
            end
            if (bus.rsp1_valid === 1'b1) begin
                r.cyc = cyc; r.res = bus.rsp1_result; r.err = bus.rsp1_err;
                q1.push_back(r);
            end
            if (bus.alu_start === 1'b1) begin
                s.cyc = cyc; s.op = bus.alu_op; s.a = bus.alu_a; s.b = bus.alu_b;
                qs.push_back(s);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d, want completion earlier", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit id, input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        qs.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mptr  = 1'b0;
    endtask

    // Holds one request until accepted; returns accept cycle or -1 on timeout.
    task automatic send(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int t_acc);
        drive(id, 1'b1, op, a, b);
        t_acc = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                t_acc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        drive(id, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 3'd0, 8'd1, 8'd1);
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        #1;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", outs());
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got r0=%b r1=%b busy=%b want r0=1 r1=0 busy=0",
                     bus.req0_ready, bus.req1_ready, busy);
        end
        drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_accept got busy=%b want 0", busy);
        end
        mptr = 1'b0;
    endtask

    task automatic test_single_add();
        int t;
        clear_q();
        alu_delay = 3;
        alu_never = 1'b0;
        send(0, 3'd0, 8'd5, 8'd3, t);
        repeat (8) @(negedge clk);
        vectors++;
        if (t < 0) begin miscompares++; $display("FAIL add_accept got none want accept"); end
        vectors++;
        if (qs.size() != 1) begin
            miscompares++; $display("FAIL add_start_count got %0d want 1", qs.size());
        end else begin
            vectors++;
            if (qs[0].cyc != t + 1) begin miscompares++; $display("FAIL add_start_cycle got %0d want %0d", qs[0].cyc, t + 1); end
            vectors++;
            if ({qs[0].op, qs[0].a, qs[0].b} !== {3'd0, 8'd5, 8'd3}) begin
                miscompares++; $display("FAIL add_alu_inputs got %h/%h/%h want 0/05/03", qs[0].op, qs[0].a, qs[0].b);
            end
        end
        vectors++;
        if (q0.size() != 1) begin
            miscompares++; $display("FAIL add_rsp0_count got %0d want 1", q0.size());
        end else begin
            vectors++;
            if (q0[0].cyc != t + 5 || q0[0].res !== 16'h0008 || q0[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL add_rsp0 got cyc=%0d res=%h err=%b want cyc=%0d res=0008 err=0", q0[0].cyc, q0[0].res, q0[0].err, t + 5);
            end
        end
        vectors++;
        if (q1.size() != 0) begin miscompares++; $display("FAIL add_rsp1_quiet got %0d pulses want 0", q1.size()); end
        mptr = 1'b1;
    endtask

    task automatic test_round_robin();
        int g[4];
        int n;
        bit exp_ptr;
        apply_reset();
        clear_q();
        alu_delay = 2;
        drive(0, 1'b1, 3'd2, 8'hFD, 8'd4);
        drive(1, 1'b1, 3'd1, 8'd10, 8'd20);
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            #1;
            if (bus.req0_ready === 1'b1) begin g[n] = 0; n++; end
            else if (bus.req1_ready === 1'b1) begin g[n] = 1; n++; end
            @(negedge clk);
        end
        drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
        repeat (8) @(negedge clk);
        vectors++;
        if (n != 4) begin
            miscompares++; $display("FAIL rr_grants got %0d want 4", n);
        end else begin
            exp_ptr = mptr;
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (g[k] != int'(exp_ptr)) begin miscompares++; $display("FAIL rr_order[%0d] got %0d want %0d", k, g[k], exp_ptr); end
                exp_ptr = ~exp_ptr;
            end
            mptr = exp_ptr;
        end
        vectors++;
        if (q0.size() != 2 || q1.size() != 2) begin
            miscompares++; $display("FAIL rr_rsp_counts got %0d/%0d want 2/2", q0.size(), q1.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (q0[k].res !== 16'hFFF4 || q0[k].err !== 1'b0) begin miscompares++; $display("FAIL rr_rsp0[%0d] got %h err=%b want FFF4 err=0", k, q0[k].res, q0[k].err); end
                vectors++;
                if (q1[k].res !== 16'hFFF6 || q1[k].err !== 1'b0) begin miscompares++; $display("FAIL rr_rsp1[%0d] got %h err=%b want FFF6 err=0", k, q1[k].res, q1[k].err); end
            end
        end
    endtask

    task automatic test_reserved();
        int t;
        int t2;
        int g;
        alu_delay = 1;
        send(0, 3'd0, 8'd1, 8'd1, t);
        repeat (5) @(negedge clk);
        mptr = 1'b1;
        clear_q();
        send(1, 3'd7, 8'h12, 8'h34, t);
        #3;
        vectors++;
        if (qs.size() != 0) begin miscompares++; $display("FAIL rsvd_no_start got %0d starts want 0", qs.size()); end
        vectors++;
        if (q1.size() != 1) begin
            miscompares++; $display("FAIL rsvd_rsp1_count got %0d want 1", q1.size());
        end else begin
            vectors++;
            if (q1[0].cyc != t + 1 || q1[0].res !== 16'h0000 || q1[0].err !== 1'b1) begin
                miscompares++;
                $display("FAIL rsvd_rsp1 got cyc=%0d res=%h err=%b want cyc=%0d res=0000 err=1", q1[0].cyc, q1[0].res, q1[0].err, t + 1);
            end
        end
        mptr = 1'b0;
        drive(0, 1'b1, 3'd0, 8'd2, 8'd2);
        drive(1, 1'b1, 3'd0, 8'd3, 8'd3);
        g = -1;
        t2 = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.req0_ready === 1'b1) begin g = 0; t2 = cyc; break; end
            if (bus.req1_ready === 1'b1) begin g = 1; t2 = cyc; break; end
        end
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
        vectors++;
        if (g != int'(mptr) || t2 != t + 2) begin
            miscompares++; $display("FAIL rsvd_next_grant got id=%0d cyc=%0d want id=%0d cyc=%0d", g, t2, mptr, t + 2);
        end
        mptr = ~mptr;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_timeout();
        int t;
        int t2;
        clear_q();
        alu_never = 1'b1;
        send(0, 3'd0, 8'd9, 8'd9, t);
        #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy got %b want 1", busy); end
        @(negedge clk);
        alu_never = 1'b0;
        alu_delay = 1;
        send(1, 3'd4, 8'hF0, 8'h3C, t2);
        repeat (6) @(negedge clk);
        vectors++;
        if (q0.size() != 1) begin
            miscompares++; $display("FAIL to_rsp0_count got %0d want 1", q0.size());
        end else begin
            vectors++;
            if (q0[0].cyc != t + TO + 2 || q0[0].res !== 16'h0000 || q0[0].err !== 1'b1) begin
                miscompares++;
                $display("FAIL to_rsp0 got cyc=%0d res=%h err=%b want cyc=%0d res=0000 err=1", q0[0].cyc, q0[0].res, q0[0].err, t + TO + 2);
            end
        end
        vectors++;
        if (t2 != t + TO + 3) begin miscompares++; $display("FAIL to_next_accept got %0d want %0d", t2, t + TO + 3); end
        vectors++;
        if (q1.size() != 1 || q1[0].res !== 16'h0030 || q1[0].err !== 1'b0) begin
            miscompares++; $display("FAIL to_follow_rsp1 got count=%0d want 1 with res=0030 err=0", q1.size());
        end
        mptr = 1'b0;
    endtask

    task automatic test_done_last();
        int t;
        clear_q();
        alu_delay = TO;
        send(1, 3'd0, 8'h40, 8'h02, t);
        repeat (14) @(negedge clk);
        vectors++;
        if (q1.size() != 1) begin
            miscompares++; $display("FAIL last_rsp1_count got %0d want 1", q1.size());
        end else begin
            vectors++;
            if (q1[0].cyc != t + TO + 2 || q1[0].res !== 16'h0042 || q1[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL last_rsp1 got cyc=%0d res=%h err=%b want cyc=%0d res=0042 err=0", q1[0].cyc, q1[0].res, q1[0].err, t + TO + 2);
            end
        end
        vectors++;
        if (q0.size() != 0) begin miscompares++; $display("FAIL last_rsp0_quiet got %0d want 0", q0.size()); end
        mptr = 1'b0;
    endtask

    task automatic test_reset_wait();
        int t;
        clear_q();
        alu_never = 1'b1;
        send(0, 3'd2, 8'd7, 8'd7, t);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (outs() !== '0) begin miscompares++; $display("FAIL rstwait_outputs got %h want 0", outs()); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mptr = 1'b0;
        repeat (14) @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++; $display("FAIL rstwait_no_rsp got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        clear_q();
        alu_never = 1'b0;
        alu_delay = 2;
        send(1, 3'd6, 8'hA5, 8'h0F, t);
        repeat (8) @(negedge clk);
        vectors++;
        if (t < 0 || q1.size() != 1) begin
            miscompares++; $display("FAIL rstwait_req1 got accept=%0d count=%0d want accept and 1", t, q1.size());
        end else begin
            vectors++;
            if (q1[0].cyc != t + 4 || q1[0].res !== 16'h00AA || q1[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL rstwait_rsp1 got cyc=%0d res=%h err=%b want cyc=%0d res=00AA err=0", q1[0].cyc, q1[0].res, q1[0].err, t + 4);
            end
        end
        mptr = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int          m;
            int          d;
            int          g;
            int          t;
            int          exp_g;
            int          exp_cyc;
            int          exp_starts;
            logic [2:0]  op[2];
            logic [7:0]  a[2];
            logic [7:0]  b[2];
            logic [15:0] exp_res;
            logic        exp_err;
            m = $urandom_range(1, 3);
            d = $urandom_range(1, TO + 3);
            for (int j = 0; j < 2; j++) begin
                op[j] = 3'($urandom);
                a[j]  = 8'($urandom);
                b[j]  = 8'($urandom);
            end
            alu_delay = d;
            clear_q();
            drive(0, m[0], op[0], a[0], b[0]);
            drive(1, m[1], op[1], a[1], b[1]);
            g = -1;
            t = -1;
            for (int i = 0; i < 50; i++) begin
                #1;
                if (bus.req0_ready === 1'b1) begin g = 0; t = cyc; @(negedge clk); break; end
                if (bus.req1_ready === 1'b1) begin g = 1; t = cyc; @(negedge clk); break; end
                @(negedge clk);
            end
            drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
            drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
            repeat (TO + 6) @(negedge clk);
            exp_g = (m == 3) ? int'(mptr) : ((m == 2) ? 1 : 0);
            if (op[exp_g] == 3'd7) begin
                exp_cyc = t + 1; exp_res = 16'h0000; exp_err = 1'b1; exp_starts = 0;
            end else if (d <= TO) begin
                exp_cyc = t + d + 2; exp_res = alu_ref(op[exp_g], a[exp_g], b[exp_g]); exp_err = 1'b0; exp_starts = 1;
            end else begin
                exp_cyc = t + TO + 2; exp_res = 16'h0000; exp_err = 1'b1; exp_starts = 1;
            end
            vectors++;
            if (g != exp_g) begin miscompares++; $display("FAIL rnd%0d_grant got %0d want %0d (mask %0d)", k, g, exp_g, m); end
            vectors++;
            if (qs.size() != exp_starts) begin miscompares++; $display("FAIL rnd%0d_starts got %0d want %0d", k, qs.size(), exp_starts); end
            if (exp_g == 0) begin
                vectors++;
                if (q0.size() != 1 || q1.size() != 0) begin
                    miscompares++; $display("FAIL rnd%0d_counts got %0d/%0d want 1/0", k, q0.size(), q1.size());
                end else if (q0[0].cyc != exp_cyc || q0[0].res !== exp_res || q0[0].err !== exp_err) begin
                    miscompares++;
                    $display("FAIL rnd%0d_rsp0 got cyc=%0d res=%h err=%b want cyc=%0d res=%h err=%b", k, q0[0].cyc, q0[0].res, q0[0].err, exp_cyc, exp_res, exp_err);
                end
            end else begin
                vectors++;
                if (q1.size() != 1 || q0.size() != 0) begin
                    miscompares++; $display("FAIL rnd%0d_counts got %0d/%0d want 0/1", k, q0.size(), q1.size());
                end else if (q1[0].cyc != exp_cyc || q1[0].res !== exp_res || q1[0].err !== exp_err) begin
                    miscompares++;
                    $display("FAIL rnd%0d_rsp1 got cyc=%0d res=%h err=%b want cyc=%0d res=%h err=%b", k, q1[0].cyc, q1[0].res, q1[0].err, exp_cyc, exp_res, exp_err);
                end
            end
            mptr = (exp_g == 0);
        end
    endtask

    initial begin
        drive(0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive(1, 1'b0, 3'd0, 8'd0, 8'd0);
        test_reset();
        test_single_add();
        test_round_robin();
        test_reserved();
        test_timeout();
        test_done_last();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared `alu_top` datapath. It accepts operation requests (opcode plus two signed 8-bit operands) from two independent clients and grants them round-robin. It runs exactly one operation at a time on the ALU through its start/done handshake and returns the 16-bit result, or an error, to the requester that issued it. It sits between the client logic and `alu_top`, and owns the ALU's `start`, `op`, `in_a` and `in_b` inputs.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles allowed before an operation is aborted. Legal range is 2..255.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqN_valid`  in  1  requester N (N = 0, 1) presents an operation.
- `reqN_ready`  out  1  arbiter accepts requester N this cycle.
- `reqN_op`  in  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 reserved.
- `reqN_a`, `reqN_b`  in  8  signed operands.
- `rspN_valid`  out  1  one-cycle response pulse to requester N.
- `rspN_result`  out  16  result; valid while `rspN_valid` is high.
- `rspN_err`  out  1  error flag (reserved opcode or timeout); valid with `rspN_valid`.
- `alu_start`  out  1  one-cycle start pulse to `alu_top`.
- `alu_op`  out  3  opcode to ALU.
- `alu_a`, `alu_b`  out  8  operands to ALU.
- `alu_done`  in  1  ALU completion.
- `alu_result`  in  16  ALU result; sampled in the cycle `alu_done` is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, RESP.

**IDLE**
- The grant is computed combinationally:
  - Only one `reqN_valid` high: grant that requester.
  - Both high: grant the requester selected by the priority pointer `ptr`.
- `reqN_ready` = (state == IDLE) & (grant == N). Ready may depend combinationally on valid.
- On handshake (valid & ready):
  - Latch opcode, operands and requester id.
  - If opcode == 7, go to RESP with err=1 and result 16'h0000. The ALU is never started.
  - Otherwise go to ISSUE.

**ISSUE**
- `alu_start` = 1 for exactly this cycle.
- `alu_op`, `alu_a` and `alu_b` are registered outputs. They are driven from the latched values and held stable from ISSUE until the next accept.
- Clear the timeout counter.
- Go to WAIT.

**WAIT**
- Sample `alu_done` every cycle. `alu_done` in any other state is ignored.
- If `alu_done` is high: capture `alu_result`, set err=0, go to RESP.
- Otherwise increment the counter. If the counter equals TIMEOUT-1, go to RESP with err=1 and result 16'h0000.
- If `alu_done` rises in the same cycle the counter hits TIMEOUT-1, `alu_done` wins: the result is delivered with err=0.

**RESP**
- `rspN_valid` = 1 for this one cycle, N = latched id. `rspN_result` and `rspN_err` are registered.
- The other requester's rsp signals stay 0.
- `ptr` <= the other requester. This applies after any response, including errors.
- Go to IDLE.

**General rules**
- At most one operation is in flight.
- Requests are not queued; `reqN_valid` with no ready simply waits.
- Operands and result pass through unmodified; all sign and width handling belongs to `alu_top`.

## Timing
- **Reset** (asynchronous, immediate):
  - State = IDLE, `ptr` = 0, counter = 0.
  - All outputs 0: `alu_start`, `alu_op`, `alu_a`, `alu_b`, every rsp signal, `busy`.
  - `reqN_ready` follows the IDLE rule as soon as reset deasserts.
- **Reset mid-operation:** the operation is abandoned and no response is ever produced for it. `alu_top` is reset by the same signal.
- **Normal latency**, with accept at cycle T:
  - `alu_start` at T+1.
  - WAIT begins at T+2.
  - With `alu_done` at cycle D (D ≥ T+2): `rsp_valid` at D+1, IDLE and next accept possible at D+2.
- **Reserved opcode:** accept at T, `rsp_valid` with err=1 at T+1, next accept at T+2.
- **Timeout:** WAIT lasts exactly TIMEOUT cycles (T+2 .. T+1+TIMEOUT). `rsp_valid` with err=1 at T+2+TIMEOUT.
- `busy` is high from T+1 through the RESP cycle inclusive.

## Test plan
- **Single add.** Requester 0 sends op=0, a=5, b=3; ALU model raises done 3 cycles after start with 16'h0008.
  - Required: `alu_start` exactly once, at T+1.
  - Required: `rsp0_valid` for one cycle with result 16'h0008 and err=0.
  - Required: `rsp1_valid` never asserts.
- **Round-robin.** Both requesters hold valid continuously after reset for 4 operations (req0 mul −3×4, req1 sub 10−20).
  - Required: grant order 0, 1, 0, 1.
  - Required: results 16'hFFF4 and 16'hFFF6 each go to the correct port.
- **Reserved opcode.** Requester 1 sends op=7.
  - Required: no `alu_start`.
  - Required: `rsp1_valid` at T+1 with err=1 and result 16'h0000.
  - Required: `ptr` moves to 0.
- **Timeout.** TIMEOUT=8; ALU model never asserts done.
  - Required: `rsp_valid` with err=1 and result 0 at T+10.
  - Required: next request accepted at T+11.
- **Done on final timeout cycle.** TIMEOUT=8; done with 16'h0042 at T+9.
  - Required: response err=0, result 16'h0042.
- **Reset during WAIT.** Assert reset while the operation is in WAIT.
  - Required: all outputs 0 immediately and no response issued.
  - Required: after release, a new requester-1 request is accepted (`ptr`=0 but only requester 1 valid) and completes normally.
